// File: rtl/jtag_host_scan.sv
// jtag_host_scan: host-side JTAG scan engine.
// Turns reset/IR/DR/idle requests into TCK/TMS/TDI sequences and returns TDO.
module jtag_host_scan #(
    parameter int ClkDiv = 4,
    parameter int MaxLen = 64,
    localparam int LenW = $clog2(MaxLen + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [LenW-1:0]   req_len_i,
    input  logic [MaxLen-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);

    localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [LenW-1:0] LenMax = LenW'(MaxLen);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SHIFT,
        POST,
        RESP
    } state_t;

    state_t            state_q;
    logic [DivW-1:0]   div_q;
    logic              tck_q;
    logic              tms_q;
    logic              tdi_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              need_reset_q;
    logic              scan_q;
    logic [9:0]        pre_q;
    logic [3:0]        pre_cnt_q;
    logic [2:0]        post_q;
    logic [1:0]        post_cnt_q;
    logic [LenW-1:0]   len_q;
    logic [LenW-1:0]   bit_q;
    logic [MaxLen-1:0] data_q;
    logic [MaxLen-1:0] cap_q;

    logic [LenW-1:0]   len_d;
    logic [9:0]        pre_d;
    logic [3:0]        pre_cnt_d;
    logic [2:0]        post_d;
    logic [1:0]        post_cnt_d;
    logic              scan_d;
    logic [3:0]        sp_bits;
    logic [2:0]        sp_cnt;
    logic              do_reset;
    logic [IdxW-1:0]   bit_idx;
    logic [IdxW-1:0]   nxt_idx;

    assign bit_idx = bit_q[IdxW-1:0];
    assign nxt_idx = bit_idx + 1'b1;

    // Build the TMS prefix/suffix (LSB first) for the incoming request.
    always_comb begin
        len_d      = (req_len_i > LenMax) ? LenMax : req_len_i;
        sp_bits    = 4'b0000;
        sp_cnt     = 3'd0;
        post_d     = 3'b000;
        post_cnt_d = 2'd0;
        scan_d     = 1'b0;
        do_reset   = need_reset_q;
        unique case (req_op_i)
            2'd0: begin
                len_d    = '0;
                do_reset = 1'b1;
            end
            2'd1: begin
                scan_d = 1'b1;
                if (len_d == '0) begin
                    sp_bits    = 4'b0011;
                    sp_cnt     = 3'd3;
                    post_d     = 3'b011;
                    post_cnt_d = 2'd3;
                end else begin
                    sp_bits    = 4'b0011;
                    sp_cnt     = 3'd4;
                    post_d     = 3'b001;
                    post_cnt_d = 2'd2;
                end
            end
            2'd2: begin
                scan_d = 1'b1;
                if (len_d == '0) begin
                    sp_bits    = 4'b0001;
                    sp_cnt     = 3'd2;
                    post_d     = 3'b011;
                    post_cnt_d = 2'd3;
                end else begin
                    sp_bits    = 4'b0001;
                    sp_cnt     = 3'd3;
                    post_d     = 3'b001;
                    post_cnt_d = 2'd2;
                end
            end
            default: begin
                scan_d = 1'b0;
            end
        endcase
        if (do_reset) begin
            pre_d     = {sp_bits, 6'b011111};
            pre_cnt_d = {1'b0, sp_cnt} + 4'd6;
        end else begin
            pre_d     = {6'b000000, sp_bits};
            pre_cnt_d = {1'b0, sp_cnt};
        end
    end

    // Scan FSM with TCK divider; TMS/TDI move on TCK fall, TDO sampled on rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            div_q        <= '0;
            tck_q        <= 1'b0;
            tms_q        <= 1'b1;
            tdi_q        <= 1'b0;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            need_reset_q <= 1'b1;
            scan_q       <= 1'b0;
            pre_q        <= '0;
            pre_cnt_q    <= '0;
            post_q       <= '0;
            post_cnt_q   <= '0;
            len_q        <= '0;
            bit_q        <= '0;
            data_q       <= '0;
            cap_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        ready_q      <= 1'b0;
                        div_q        <= '0;
                        tck_q        <= 1'b0;
                        tdi_q        <= 1'b0;
                        data_q       <= req_data_i;
                        cap_q        <= '0;
                        len_q        <= len_d;
                        bit_q        <= '0;
                        scan_q       <= scan_d;
                        pre_q        <= pre_d;
                        pre_cnt_q    <= pre_cnt_d;
                        post_q       <= post_d;
                        post_cnt_q   <= post_cnt_d;
                        need_reset_q <= 1'b0;
                        if (pre_cnt_d != 4'd0) begin
                            state_q <= PRE;
                            tms_q   <= pre_d[0];
                        end else if (len_d != '0) begin
                            state_q <= SHIFT;
                            tms_q   <= 1'b0;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                PRE, SHIFT, POST: begin
                    if (div_q != DivLast) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        tck_q <= ~tck_q;
                        if (!tck_q) begin
                            if (state_q == SHIFT && scan_q) begin
                                cap_q[bit_idx] <= tdo_i;
                            end
                        end else if (state_q == PRE) begin
                            if (pre_cnt_q != 4'd1) begin
                                pre_q     <= pre_q >> 1;
                                pre_cnt_q <= pre_cnt_q - 4'd1;
                                tms_q     <= pre_q[1];
                            end else if (len_q != '0) begin
                                state_q <= SHIFT;
                                tms_q   <= scan_q & (len_q == LenW'(1));
                                tdi_q   <= scan_q & data_q[0];
                            end else if (post_cnt_q != 2'd0) begin
                                state_q <= POST;
                                tms_q   <= post_q[0];
                            end else begin
                                state_q     <= RESP;
                                rsp_valid_q <= 1'b1;
                            end
                        end else if (state_q == SHIFT) begin
                            if (bit_q != len_q - LenW'(1)) begin
                                bit_q <= bit_q + LenW'(1);
                                tms_q <= scan_q & (bit_q + LenW'(2) == len_q);
                                tdi_q <= scan_q & data_q[nxt_idx];
                            end else begin
                                tdi_q <= 1'b0;
                                if (post_cnt_q != 2'd0) begin
                                    state_q <= POST;
                                    tms_q   <= post_q[0];
                                end else begin
                                    state_q     <= RESP;
                                    rsp_valid_q <= 1'b1;
                                end
                            end
                        end else begin
                            if (post_cnt_q != 2'd1) begin
                                post_q     <= post_q >> 1;
                                post_cnt_q <= post_cnt_q - 2'd1;
                                tms_q      <= post_q[1];
                            end else begin
                                state_q     <= RESP;
                                rsp_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = cap_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_host_scan.sv
// tb_jtag_host_scan: directed bench for jtag_host_scan.
// A small TAP model (IR capture 5'b00101, IDCODE 0x00000001) answers on TDO.
module tb_jtag_host_scan;

    localparam int ClkDiv = 4;
    localparam int MaxLen = 64;
    localparam int LenW = $clog2(MaxLen + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready_o;
    logic [1:0]        req_op = 2'd0;
    logic [LenW-1:0]   req_len = '0;
    logic [MaxLen-1:0] req_data = '0;
    logic              rsp_valid_o;
    logic              rsp_ready = 1'b0;
    logic [MaxLen-1:0] rsp_data_o;
    logic              tck_o;
    logic              tms_o;
    logic              tdi_o;
    logic              tdo = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jtag_host_scan #(
        .ClkDiv(ClkDiv),
        .MaxLen(MaxLen)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready_o),
        .req_op_i   (req_op),
        .req_len_i  (req_len),
        .req_data_i (req_data),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data_o),
        .tck_o      (tck_o),
        .tms_o      (tms_o),
        .tdi_o      (tdi_o),
        .tdo_i      (tdo)
    );

    // TCK edge log
    int   cyc = 0;
    int   rcnt = 0;
    int   fcnt = 0;
    int   rise_cyc[0:4095];
    int   fall_cyc[0:4095];
    logic tms_log[0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge tck_o) begin
        if (rcnt < 4096) begin
            tms_log[rcnt]  = tms_o;
            rise_cyc[rcnt] = cyc;
        end
        rcnt = rcnt + 1;
    end

    always @(negedge tck_o) begin
        if (fcnt < 4096) fall_cyc[fcnt] = cyc;
        fcnt = fcnt + 1;
    end

    // TAP model
    typedef enum logic [3:0] {
        TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR,
        UDR, SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR
    } tap_t;

    tap_t        ts = TLR;
    logic [4:0]  ir = 5'h01;
    logic [4:0]  ir_sr = 5'h00;
    logic [31:0] dr_sr = 32'h0;

    always @(posedge tck_o) begin
        case (ts)
            TLR:  ir <= 5'h01;
            CIR:  ir_sr <= 5'b00101;
            SHIR: ir_sr <= {tdi_o, ir_sr[4:1]};
            UIR:  ir <= ir_sr;
            CDR:  dr_sr <= (ir == 5'h01) ? 32'h1 : 32'h0;
            SHDR: dr_sr <= (ir == 5'h01) ? {tdi_o, dr_sr[31:1]}
                                         : {31'h0, tdi_o};
            default: ;
        endcase
        case (ts)
            TLR:  ts <= tms_o ? TLR : RTI;
            RTI:  ts <= tms_o ? SDS : RTI;
            SDS:  ts <= tms_o ? SIS : CDR;
            CDR:  ts <= tms_o ? E1DR : SHDR;
            SHDR: ts <= tms_o ? E1DR : SHDR;
            E1DR: ts <= tms_o ? UDR : PDR;
            PDR:  ts <= tms_o ? E2DR : PDR;
            E2DR: ts <= tms_o ? UDR : SHDR;
            UDR:  ts <= tms_o ? SDS : RTI;
            SIS:  ts <= tms_o ? TLR : CIR;
            CIR:  ts <= tms_o ? E1IR : SHIR;
            SHIR: ts <= tms_o ? E1IR : SHIR;
            E1IR: ts <= tms_o ? UIR : PIR;
            PIR:  ts <= tms_o ? E2IR : PIR;
            E2IR: ts <= tms_o ? UIR : SHIR;
            default: ts <= tms_o ? SDS : RTI;
        endcase
    end

    always @(negedge tck_o) begin
        tdo <= (ts == SHDR) ? dr_sr[0] : (ts == SHIR) ? ir_sr[0] : 1'b0;
    end

    // Drive one request, wait for its response, optionally acknowledge it.
    task automatic run_op(input logic [1:0] op, input logic [LenW-1:0] len,
                          input logic [MaxLen-1:0] data, input bit ack,
                          output logic [MaxLen-1:0] rsp, output int base);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready_o && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: req_ready_o=%b required 1", req_ready_o);
        end
        base      = rcnt;
        req_valid = 1'b1;
        req_op    = op;
        req_len   = len;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid_o && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rsp_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_valid_wait: rsp_valid_o=%b required 1", rsp_valid_o);
        end
        rsp = rsp_data_o;
        if (ack) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({tck_o, tms_o, tdi_o, rsp_valid_o} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_pins: tck/tms/tdi/rsp_valid=%b required 0100",
                     {tck_o, tms_o, tdi_o, rsp_valid_o});
        end
        n_checks++;
        if (rsp_data_o !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h required 0", rsp_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", req_ready_o);
        end
    endtask

    task automatic test_tap_reset();
        logic [MaxLen-1:0] rsp;
        logic [5:0]        seq;
        int                b;
        int                fb;
        fb = fcnt;
        run_op(2'd0, '0, '0, 1'b1, rsp, b);
        n_checks++;
        if (rcnt - b !== 6) begin
            n_fail++;
            $display("FAIL tap_reset_tck_count: got %0d required 6", rcnt - b);
        end
        for (int i = 0; i < 6; i++) seq[i] = tms_log[b + i];
        n_checks++;
        if (seq !== 6'b011111) begin
            n_fail++;
            $display("FAIL tap_reset_tms: got %b required 011111", seq);
        end
        n_checks++;
        if (rsp !== 64'h0) begin
            n_fail++;
            $display("FAIL tap_reset_rsp: got %h required 0", rsp);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rise_cyc[b + i + 1] - rise_cyc[b + i] !== 2 * ClkDiv) begin
                n_fail++;
                $display("FAIL tck_period_%0d: got %0d required %0d", i,
                         rise_cyc[b + i + 1] - rise_cyc[b + i], 2 * ClkDiv);
            end
        end
        n_checks++;
        if (fall_cyc[fb] - rise_cyc[b] !== ClkDiv) begin
            n_fail++;
            $display("FAIL tck_high_phase: got %0d required %0d",
                     fall_cyc[fb] - rise_cyc[b], ClkDiv);
        end
    endtask

    task automatic test_ir_scan();
        logic [MaxLen-1:0] rsp;
        logic [5:0]        seq;
        int                b;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(2'd1, LenW'(5), 64'h11, 1'b1, rsp, b);
        n_checks++;
        if (rcnt - b !== 17) begin
            n_fail++;
            $display("FAIL ir_tck_count: got %0d required 17", rcnt - b);
        end
        for (int i = 0; i < 6; i++) seq[i] = tms_log[b + i];
        n_checks++;
        if (seq !== 6'b011111) begin
            n_fail++;
            $display("FAIL ir_auto_reset_tms: got %b required 011111", seq);
        end
        n_checks++;
        if (rsp !== 64'h05) begin
            n_fail++;
            $display("FAIL ir_capture: got %h required 05", rsp);
        end
        n_checks++;
        if (ir !== 5'h11) begin
            n_fail++;
            $display("FAIL ir_update: got %h required 11", ir);
        end
    endtask

    task automatic test_idcode();
        logic [MaxLen-1:0] rsp;
        int                b;
        run_op(2'd1, LenW'(5), 64'h01, 1'b1, rsp, b);
        n_checks++;
        if (ir !== 5'h01) begin
            n_fail++;
            $display("FAIL idcode_ir: got %h required 01", ir);
        end
        run_op(2'd2, LenW'(32), 64'h0, 1'b1, rsp, b);
        n_checks++;
        if (rcnt - b !== 37) begin
            n_fail++;
            $display("FAIL dr_tck_count: got %0d required 37", rcnt - b);
        end
        n_checks++;
        if (rsp !== 64'h1) begin
            n_fail++;
            $display("FAIL idcode_value: got %h required 1", rsp);
        end
    endtask

    task automatic test_rsp_hold();
        logic [MaxLen-1:0] rsp;
        int                b;
        run_op(2'd2, LenW'(32), 64'h0, 1'b0, rsp, b);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid_o, req_ready_o, tck_o} !== 3'b100) begin
                n_fail++;
                $display("FAIL hold_pins_%0d: valid/ready/tck=%b required 100",
                         i, {rsp_valid_o, req_ready_o, tck_o});
            end
            n_checks++;
            if (rsp_data_o !== 64'h1) begin
                n_fail++;
                $display("FAIL hold_data_%0d: got %h required 1", i, rsp_data_o);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_release: ready/valid=%b required 10",
                     {req_ready_o, rsp_valid_o});
        end
    endtask

    task automatic test_len_edges();
        logic [MaxLen-1:0] rsp;
        logic [4:0]        seq;
        int                b;
        run_op(2'd2, '0, 64'hFFFF, 1'b1, rsp, b);
        n_checks++;
        if (rcnt - b !== 5) begin
            n_fail++;
            $display("FAIL dr0_tck_count: got %0d required 5", rcnt - b);
        end
        for (int i = 0; i < 5; i++) seq[i] = tms_log[b + i];
        n_checks++;
        if (seq !== 5'b01101) begin
            n_fail++;
            $display("FAIL dr0_tms: got %b required 01101", seq);
        end
        n_checks++;
        if (rsp !== 64'h0) begin
            n_fail++;
            $display("FAIL dr0_rsp: got %h required 0", rsp);
        end
        run_op(2'd2, LenW'(MaxLen + 5), 64'h0123_4567_89AB_CDEF, 1'b1, rsp, b);
        n_checks++;
        if (rcnt - b !== MaxLen + 5) begin
            n_fail++;
            $display("FAIL clamp_tck_count: got %0d required %0d",
                     rcnt - b, MaxLen + 5);
        end
        n_checks++;
        if (rsp !== 64'h89AB_CDEF_0000_0001) begin
            n_fail++;
            $display("FAIL clamp_rsp: got %h required 89abcdef00000001", rsp);
        end
    endtask

    task automatic test_idle();
        logic [MaxLen-1:0] rsp;
        logic [2:0]        seq;
        int                b;
        run_op(2'd3, LenW'(3), 64'hFF, 1'b1, rsp, b);
        n_checks++;
        if (rcnt - b !== 3) begin
            n_fail++;
            $display("FAIL idle_tck_count: got %0d required 3", rcnt - b);
        end
        for (int i = 0; i < 3; i++) seq[i] = tms_log[b + i];
        n_checks++;
        if (seq !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_tms: got %b required 000", seq);
        end
        n_checks++;
        if (rsp !== 64'h0) begin
            n_fail++;
            $display("FAIL idle_rsp: got %h required 0", rsp);
        end
    endtask

    task automatic test_abort();
        logic [MaxLen-1:0] rsp;
        logic [5:0]        seq;
        int                b;
        int                t;
        @(negedge clk);
        b         = rcnt;
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_len   = LenW'(32);
        req_data  = 64'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (rcnt - b < 10 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (rcnt - b < 10) begin
            n_fail++;
            $display("FAIL abort_reach_shift: tck edges %0d required 10", rcnt - b);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tck_o, tms_o, rsp_valid_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL abort_pins: tck/tms/valid=%b required 010",
                     {tck_o, tms_o, rsp_valid_o});
        end
        rst = 1'b0;
        run_op(2'd2, LenW'(32), 64'h0, 1'b1, rsp, b);
        n_checks++;
        if (rcnt - b !== 43) begin
            n_fail++;
            $display("FAIL abort_next_tck_count: got %0d required 43", rcnt - b);
        end
        for (int i = 0; i < 6; i++) seq[i] = tms_log[b + i];
        n_checks++;
        if (seq !== 6'b011111) begin
            n_fail++;
            $display("FAIL abort_next_tms: got %b required 011111", seq);
        end
        n_checks++;
        if (rsp !== 64'h1) begin
            n_fail++;
            $display("FAIL abort_next_rsp: got %h required 1", rsp);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_tap_reset();
        test_ir_scan();
        test_idcode();
        test_rsp_hold();
        test_len_edges();
        test_idle();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
